// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte-stream requesters share one UART
// transmitter, holding ownership for a whole message with an idle-timeout release.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters this cycle, no byte moves
// OWNED | owner g streams bytes straight through to the transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_pulse
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [OW-1:0] pick;
    logic          any_valid;
    logic          owned;
    logic          xfer;
    logic          xfer_last;
    logic          timeout_hit;

    // Search starts just past the previous owner so streams alternate fairly.
    always_comb begin
        int idx;
        idx       = 0;
        pick      = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_owner_q) + i) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = OW'(idx);
            end
        end
    end

    assign owned       = (state_q == OWNED);
    assign tx_valid    = owned & req_valid[owner_q];
    assign tx_data     = owned ? req_data[int'(owner_q)*8 +: 8] : 8'h00;
    assign xfer        = tx_valid & tx_ready;
    assign xfer_last   = xfer & req_last[owner_q];
    // A completing last byte takes precedence over a simultaneous timeout.
    assign timeout_hit = owned && (idle_cnt_q == TIMEOUT_VAL) && !xfer_last;
    assign timeout_pulse = timeout_hit;

    always_comb begin
        req_ready = '0;
        grant     = '0;
        if (owned) begin
            req_ready[owner_q] = tx_ready;
            grant[owner_q]     = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        idle_cnt_d   = idle_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = OWNED;
                    owner_d    = pick;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                if (xfer_last || timeout_hit) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    idle_cnt_d   = '0;
                end else if (xfer) begin
                    idle_cnt_d = '0;
                end else if (!req_valid[owner_q] && (idle_cnt_q != TIMEOUT_VAL)) begin
                    // Back-pressure with data pending holds the count.
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter with two requesters and a timeout of 8.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .req_data(req_data),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .grant(grant),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] data;
        logic [1:0]  valid;
        logic [1:0]  last;
        logic        txr;
        logic [1:0]  e_grant;
        logic [1:0]  e_rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic rst, input logic [15:0] data,
                                input logic [1:0] valid, input logic [1:0] last, input logic txr,
                                input logic [1:0] e_grant, input logic [1:0] e_rdy,
                                input logic e_txv, input logic [7:0] e_txd, input logic e_to);
        vec_t v;
        v.name = name; v.rst = rst; v.data = data; v.valid = valid; v.last = last; v.txr = txr;
        v.e_grant = e_grant; v.e_rdy = e_rdy; v.e_txv = e_txv; v.e_txd = e_txd; v.e_to = e_to;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        reset     = v.rst;
        req_data  = v.data;
        req_valid = v.valid;
        req_last  = v.last;
        tx_ready  = v.txr;
        @(negedge clk);
        chk({v.name, ".grant"}, 8'(grant), 8'(v.e_grant));
        chk({v.name, ".req_ready"}, 8'(req_ready), 8'(v.e_rdy));
        chk({v.name, ".tx_valid"}, 8'(tx_valid), 8'(v.e_txv));
        chk({v.name, ".timeout"}, 8'(timeout_pulse), 8'(v.e_to));
        if (v.e_txv) chk({v.name, ".tx_data"}, tx_data, v.e_txd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;

        tbl.push_back(mk("rst",   0, 16'h0000, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // single message from requester 0
        tbl.push_back(mk("a0",    1, 16'h0041, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("a1",    1, 16'h0041, 2'b01, 2'b00, 1, 2'b01, 2'b01, 1, 8'h41, 0));
        tbl.push_back(mk("a2",    1, 16'h0042, 2'b01, 2'b01, 1, 2'b01, 2'b01, 1, 8'h42, 0));
        tbl.push_back(mk("a3",    1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // contention from reset, alternating owners
        tbl.push_back(mk("b_rst", 0, 16'hB0A0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("b0",    1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("b1",    1, 16'hB0A0, 2'b11, 2'b10, 1, 2'b01, 2'b01, 1, 8'hA0, 0));
        tbl.push_back(mk("b2",    1, 16'hB0A1, 2'b11, 2'b01, 1, 2'b01, 2'b01, 1, 8'hA1, 0));
        tbl.push_back(mk("b3",    1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("b4",    1, 16'hB0A0, 2'b11, 2'b10, 0, 2'b10, 2'b00, 1, 8'hB0, 0));
        tbl.push_back(mk("b5",    1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b10, 2'b10, 1, 8'hB0, 0));
        tbl.push_back(mk("b6",    1, 16'hB1A0, 2'b11, 2'b10, 1, 2'b10, 2'b10, 1, 8'hB1, 0));
        tbl.push_back(mk("b7",    1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("b8",    1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b01, 2'b01, 1, 8'hA0, 0));
        tbl.push_back(mk("b9",    1, 16'hB0A1, 2'b11, 2'b01, 1, 2'b01, 2'b01, 1, 8'hA1, 0));
        tbl.push_back(mk("b10",   1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("b11",   1, 16'hB0A0, 2'b11, 2'b00, 1, 2'b10, 2'b10, 1, 8'hB0, 0));
        tbl.push_back(mk("b12",   1, 16'hB1A0, 2'b11, 2'b10, 1, 2'b10, 2'b10, 1, 8'hB1, 0));
        tbl.push_back(mk("b13",   1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // back-pressure on requester 1 for 20 cycles
        tbl.push_back(mk("p0",    1, 16'h5A00, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk("p_hold", 1, 16'h5A00, 2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 8'h5A, 0));
        tbl.push_back(mk("p21",   1, 16'h5A00, 2'b10, 2'b10, 1, 2'b10, 2'b10, 1, 8'h5A, 0));
        tbl.push_back(mk("p22",   1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // timeout: requester 0 stalls after one byte, requester 1 waits
        tbl.push_back(mk("t0",    1, 16'h0010, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("t1",    1, 16'h0010, 2'b01, 2'b00, 1, 2'b01, 2'b01, 1, 8'h10, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk("t_idle", 1, 16'h7700, 2'b10, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 0));
        tbl.push_back(mk("t10",   1, 16'h7700, 2'b10, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 1));
        tbl.push_back(mk("t11",   1, 16'h7700, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("t12",   1, 16'h7700, 2'b10, 2'b10, 1, 2'b10, 2'b10, 1, 8'h77, 0));
        tbl.push_back(mk("t13",   1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // last byte lands on the cycle the idle count reaches the limit
        tbl.push_back(mk("c0",    1, 16'h0020, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("c1",    1, 16'h0020, 2'b01, 2'b00, 1, 2'b01, 2'b01, 1, 8'h20, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk("c_idle", 1, 16'h0000, 2'b00, 2'b00, 1, 2'b01, 2'b01, 0, 8'h00, 0));
        tbl.push_back(mk("c10",   1, 16'h0021, 2'b01, 2'b01, 1, 2'b01, 2'b01, 1, 8'h21, 0));
        tbl.push_back(mk("c11",   1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("c12",   1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        // requester 1 wins (last owner 0) and starts a message
        tbl.push_back(mk("s0",    1, 16'h5150, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        tbl.push_back(mk("s1",    1, 16'h5150, 2'b11, 2'b00, 1, 2'b10, 2'b10, 1, 8'h51, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // asynchronous reset in the middle of requester 1's message
        #2;
        reset = 1'b0;
        #1;
        chk("async.grant", 8'(grant), 8'h00);
        chk("async.req_ready", 8'(req_ready), 8'h00);
        chk("async.tx_valid", 8'(tx_valid), 8'h00);
        chk("async.timeout", 8'(timeout_pulse), 8'h00);
        @(posedge clk);
        #1;
        apply(mk("r0", 1, 16'h5150, 2'b11, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));
        apply(mk("r1", 1, 16'h5150, 2'b11, 2'b00, 1, 2'b01, 2'b01, 1, 8'h50, 0));
        apply(mk("r2", 1, 16'h5152, 2'b11, 2'b01, 1, 2'b01, 2'b01, 1, 8'h52, 0));
        apply(mk("r3", 1, 16'h0000, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 8'h00, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REQ, 2, number of byte-stream requesters sharing one uart_transmitter (legal range 2..8).
  TIMEOUT_CYCLES, 1_000_000, maximum consecutive cycles with an idle granted requester before forced release.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state on rising edge.
  reset  input  1  asynchronous, active-low reset.
  req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
  req_valid  input  NUM_REQ  requester i byte valid.
  req_last  input  NUM_REQ  requester i byte is final byte of its message.
  req_ready  output  NUM_REQ  requester i byte accepted this cycle when paired with req_valid.
  tx_data  output  8  byte to uart_transmitter data_in.
  tx_valid  output  1  to uart_transmitter data_in_valid.
  tx_ready  input  1  from uart_transmitter data_in_ready.
  grant  output  NUM_REQ  one-hot owner of the transmitter; all-zero when idle.
  timeout_pulse  output  1  one-cycle flag on forced release.

Function
REQ-003 The block SHALL have two states, IDLE and OWNED; grant SHALL be all-zero exactly in IDLE and one-hot exactly in OWNED.
REQ-004 In IDLE, if any req_valid is high, the next state SHALL be OWNED with grant set to the first requester with req_valid high, searching from index (last_owner+1) mod NUM_REQ upward with wrap-around.
REQ-005 In IDLE, req_ready SHALL be all-zero and tx_valid SHALL be 0; no byte is transferred in the arbitration cycle.
REQ-006 In OWNED with owner g: tx_data = req_data[g], tx_valid = req_valid[g], req_ready[g] = tx_ready, all other req_ready bits 0 (combinational passthrough, zero added latency).
REQ-007 A transfer SHALL occur on a cycle with tx_valid and tx_ready both high in OWNED.
REQ-008 A transfer with req_last[g] high SHALL move the state to IDLE next cycle and set last_owner = g; req_last on non-transfer cycles SHALL be ignored.
REQ-009 Non-owner req_valid/req_data/req_last SHALL have no effect in OWNED; ownership never changes mid-message except by timeout.
REQ-010 Idle counter (width clog2(TIMEOUT_CYCLES+1), saturating) SHALL clear on entry to OWNED and on every transfer, increment on each OWNED cycle with req_valid[g] low, and hold on cycles with req_valid[g] high and tx_ready low (UART back-pressure never times out).
REQ-011 When the idle counter equals TIMEOUT_CYCLES in OWNED, the next state SHALL be IDLE, last_owner = g, and timeout_pulse SHALL be high for exactly that one cycle.
REQ-012 If a last-byte transfer and the timeout condition coincide, the transfer SHALL win: state goes IDLE, timeout_pulse stays 0.
REQ-013 Minimum gap between consecutive messages SHALL be one IDLE cycle; back-to-back messages from different requesters SHALL alternate per REQ-004.

Reset
REQ-014 Asserting reset (low) SHALL immediately, without a clock edge, force state IDLE, grant 0, req_ready 0, tx_valid 0, timeout_pulse 0, idle counter 0, last_owner NUM_REQ-1 (requester 0 has first priority).
REQ-015 Reset asserted mid-message SHALL abandon the message; after release, arbitration restarts per REQ-004 with no stored partial state.
REQ-016 Reset deassertion SHALL be treated synchronously to clk by the surrounding system; the block samples inputs starting on the first rising edge after release.

Verification (NUM_REQ=2, TIMEOUT_CYCLES=8)
REQ-017 Single message: req 0 sends 0x41,0x42(last), tx_ready always 1 -> grant=01 one cycle after valid, tx_data 0x41 then 0x42 on consecutive cycles, grant=00 after.
REQ-018 Contention: req 0 and 1 both valid from reset, each sending 2-byte messages repeatedly -> order req0, req1, req0, req1, one IDLE cycle between messages, no byte dropped or duplicated.
REQ-019 Back-pressure: req 1 owns, tx_ready held low 20 cycles with req_valid[1] high -> no timeout_pulse, byte 0x5A transferred when tx_ready rises.
REQ-020 Timeout: req 0 sends 0x10 (not last) then drops valid -> timeout_pulse high exactly 8 OWNED-idle cycles later, grant=00 next, pending req 1 granted next.
REQ-021 Coincidence: last-byte transfer on the cycle counter would hit 8 -> IDLE, timeout_pulse 0.
REQ-022 Async reset mid-message: reset low between cycles -> grant, req_ready, tx_valid 0 before the next edge; after release req 0 wins first.
